// File: rtl/des_round_engine.sv
// Iterative DES block engine: 16 Feistel rounds, ROUNDS_PER_CYCLE rounds per clock, valid/ready in and out.
// Optional build macro DES_ZEROIZE_EN clears L/R, C/D and out_data when the result is handed off.
module des_round_engine #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_mode,
   input  logic [0:63] in_data,
   input  logic [0:63] in_key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [0:63] out_data
);

   localparam int N = 16 / ROUNDS_PER_CYCLE;
   localparam logic [3:0] RC_LAST = 4'(N - 1);

   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
       ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // S-boxes S1..S8, each 4 rows of 16, row-major
   localparam int SBOX [512] = '{
      14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
      15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
      10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
      7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
      2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
      12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
      4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
      13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

   function automatic logic [0:63] perm_ip(input logic [0:63] x);
      for (int i = 0; i < 64; i++) perm_ip[i] = x[IP_T[i] - 1];
   endfunction

   function automatic logic [0:63] perm_fp(input logic [0:63] x);
      for (int i = 0; i < 64; i++) perm_fp[i] = x[FP_T[i] - 1];
   endfunction

   function automatic logic [0:55] perm_pc1(input logic [0:63] x);
      for (int i = 0; i < 56; i++) perm_pc1[i] = x[PC1_T[i] - 1];
   endfunction

   function automatic logic [0:47] perm_pc2(input logic [0:55] x);
      for (int i = 0; i < 48; i++) perm_pc2[i] = x[PC2_T[i] - 1];
   endfunction

   function automatic logic [0:31] feistel(input logic [0:31] r, input logic [0:47] k);
      logic [0:47] x;
      logic [5:0]  b;
      logic [0:31] s;
      for (int i = 0; i < 48; i++) x[i] = r[E_T[i] - 1];
      x = x ^ k;
      for (int i = 0; i < 8; i++) begin
         b = x[6*i +: 6];
         s[4*i +: 4] = 4'(SBOX[i*64 + int'({b[5], b[0]})*16 + int'(b[4:1])]);
      end
      for (int i = 0; i < 32; i++) feistel[i] = s[P_T[i] - 1];
   endfunction

   function automatic int shift_amt(input int r);
      return (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
   endfunction

   function automatic logic [0:27] rotl(input logic [0:27] x, input int s);
      rotl = (s == 2) ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
   endfunction

   function automatic logic [0:27] rotr(input logic [0:27] x, input int s);
      rotr = (s == 2) ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state;
   logic [3:0]  rc;
   logic        mode_q;
   logic [0:31] l_q, r_q;
   logic [0:27] c_q, d_q;

   logic [0:31] l_v, r_v, t_v;
   logic [0:27] c_v, d_v;
   int          rnd;

   // Chain of ROUNDS_PER_CYCLE rounds; decrypt walks the key schedule backwards (K16 first)
   always_comb begin
      l_v = l_q;
      r_v = r_q;
      c_v = c_q;
      d_v = d_q;
      t_v = '0;
      rnd = 0;
      for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
         rnd = int'(rc) * ROUNDS_PER_CYCLE + k + 1;
         if (!mode_q) begin
            c_v = rotl(c_v, shift_amt(rnd));
            d_v = rotl(d_v, shift_amt(rnd));
         end else if (rnd != 1) begin
            c_v = rotr(c_v, shift_amt(18 - rnd));
            d_v = rotr(d_v, shift_amt(18 - rnd));
         end
         t_v = l_v ^ feistel(r_v, perm_pc2({c_v, d_v}));
         l_v = r_v;
         r_v = t_v;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         rc        <= '0;
         mode_q    <= 1'b0;
         l_q       <= '0;
         r_q       <= '0;
         c_q       <= '0;
         d_q       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  {l_q, r_q} <= perm_ip(in_data);
                  {c_q, d_q} <= perm_pc1(in_key);
                  mode_q     <= in_mode;
                  rc         <= '0;
                  in_ready   <= 1'b0;
                  state      <= S_RUN;
               end
            end
            S_RUN: begin
               l_q <= l_v;
               r_q <= r_v;
               c_q <= c_v;
               d_q <= d_v;
               if (rc == RC_LAST) begin
                  out_data  <= perm_fp({r_v, l_v});
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  rc <= rc + 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
`ifdef DES_ZEROIZE_EN
                  out_data  <= '0;
                  l_q       <= '0;
                  r_q       <= '0;
                  c_q       <= '0;
                  d_q       <= '0;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_des_round_engine.sv
// Directed-vector bench for des_round_engine across all legal unroll depths (1, 2, 4, 8, 16 rounds/cycle).
module tb_des_round_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_mode;
   logic [0:63] in_data;
   logic [0:63] in_key;
   logic        in_valid_a  [5];
   logic        in_ready_a  [5];
   logic        out_valid_a [5];
   logic        out_ready_a [5];
   logic [0:63] out_data_a  [5];

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      des_round_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid_a[g]),
         .in_ready  (in_ready_a[g]),
         .in_mode   (in_mode),
         .in_data   (in_data),
         .in_key    (in_key),
         .out_valid (out_valid_a[g]),
         .out_ready (out_ready_a[g]),
         .out_data  (out_data_a[g])
      );
   end

   localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
   localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] C1 = 64'h85E813540F0AB405;
   localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
   localparam logic [63:0] P2 = 64'h8787878787878787;
   localparam logic [63:0] C2 = 64'h0000000000000000;

   typedef struct {
      int          idx;
      logic        mode;
      logic [63:0] key;
      logic [63:0] data;
      logic [63:0] expv;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Caller is positioned just after a rising edge.
   task automatic run_block(input int idx, input logic mode, input logic [63:0] key,
                            input logic [63:0] data, input logic [63:0] expv, input string name);
      int cyc;
      cyc = 0;
      while (in_ready_a[idx] !== 1'b1 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({name, " in_ready before accept"}, 64'(in_ready_a[idx]), 64'd1);
      in_mode          = mode;
      in_key           = key;
      in_data          = data;
      out_ready_a[idx] = 1'b1;
      in_valid_a[idx]  = 1'b1;
      @(posedge clk); #1;
      in_valid_a[idx] = 1'b0;
      in_mode         = ~mode;
      in_key          = ~key;
      in_data         = ~data;
      cyc = 0;
      while (out_valid_a[idx] !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({name, " latency"}, 64'(cyc), 64'(16 >> idx));
      check({name, " out_data"}, out_data_a[idx], expv);
      @(posedge clk); #1;
      check({name, " in_ready after handoff"}, 64'(in_ready_a[idx]), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      for (int i = 0; i < 5; i++) begin
         vecs[2*i]   = '{i, 1'b0, K1, P1, C1};
         vecs[2*i+1] = '{i, 1'b1, K1, C1, P1};
      end
      vecs[10] = '{0, 1'b0, K2, P2, C2};
      vecs[11] = '{4, 1'b1, K2, C2, P2};

      rst_n   = 1'b0;
      in_mode = 1'b0;
      in_data = '0;
      in_key  = '0;
      for (int i = 0; i < 5; i++) begin
         in_valid_a[i]  = 1'b0;
         out_ready_a[i] = 1'b1;
      end

      // Reset values
      #1;
      check("reset in_ready", 64'(in_ready_a[0]), 64'd0);
      check("reset out_valid", 64'(out_valid_a[0]), 64'd0);
      check("reset out_data", out_data_a[0], 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready first edge after reset", 64'(in_ready_a[4]), 64'd1);

      foreach (vecs[i])
         run_block(vecs[i].idx, vecs[i].mode, vecs[i].key, vecs[i].data, vecs[i].expv,
                   $sformatf("vec%0d R=%0d", i, 1 << vecs[i].idx));

      // Backpressure plus input masking during RUN and DONE
      in_mode        = 1'b0;
      in_key         = K1;
      in_data        = P1;
      out_ready_a[0] = 1'b0;
      in_valid_a[0]  = 1'b1;
      @(posedge clk); #1;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         in_valid_a[0] = ~in_valid_a[0];
         in_data       = {$urandom, $urandom};
         in_key        = {$urandom, $urandom};
         in_mode       = ~in_mode;
         if (in_ready_a[0] !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      check("masking in_ready during RUN", 64'(bad), 64'd0);
      check("backpressure out_valid", 64'(out_valid_a[0]), 64'd1);
      check("backpressure out_data", out_data_a[0], C1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         in_valid_a[0] = ~in_valid_a[0];
         in_data       = {$urandom, $urandom};
         if (out_valid_a[0] !== 1'b1 || out_data_a[0] !== C1 || in_ready_a[0] !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      check("DONE held 20 cycles stable", 64'(bad), 64'd0);
      in_valid_a[0]  = 1'b0;
      out_ready_a[0] = 1'b1;
      @(posedge clk); #1;
      check("release in_ready", 64'(in_ready_a[0]), 64'd1);
      check("release out_valid", 64'(out_valid_a[0]), 64'd0);
`ifdef DES_ZEROIZE_EN
      check("zeroized out_data", out_data_a[0], 64'd0);
`else
      check("retained out_data", out_data_a[0], C1);
`endif

      // Reset in the middle of a block (R=1, rc=7)
      in_mode       = 1'b1;
      in_key        = K1;
      in_data       = C1;
      in_valid_a[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_a[0] = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrun reset out_valid", 64'(out_valid_a[0]), 64'd0);
      check("midrun reset out_data", out_data_a[0], 64'd0);
      check("midrun reset in_ready", 64'(in_ready_a[0]), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready after midrun reset", 64'(in_ready_a[0]), 64'd1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid_a[0] !== 1'b0 || out_data_a[0] !== 64'd0) bad++;
         @(posedge clk); #1;
      end
      check("no output from aborted block", 64'(bad), 64'd0);
      run_block(0, 1'b1, K1, C1, P1, "fresh block after reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/des_round_engine.md
# des_round_engine

Iterative, parametrised DES block engine built around the existing `feistel` round function. Accepts a 64-bit block, a 64-bit key and a mode (encrypt/decrypt) through a valid/ready handshake. Runs the 16 DES rounds with an on-the-fly forward or reverse key schedule and returns the result through a second valid/ready handshake. Unroll depth is a parameter, trading area for latency.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds computed per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error. `N = 16 / ROUNDS_PER_CYCLE`.
- `clk`, input, 1: the block's one clock; all state changes on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: input block presented.
- `in_ready`, output, 1: engine can accept a block.
- `in_mode`, input, 1: 0 = encrypt, 1 = decrypt.
- `in_data`, input, [0:63]: plaintext or ciphertext; bit 0 is DES bit 1.
- `in_key`, input, [0:63]: DES key including parity bits; parity bits are ignored.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: downstream accepts the result.
- `out_data`, output, [0:63]: result, registered.

## Operation
- States:
  - IDLE: `in_ready` = 1.
  - RUN: holds round counter `rc`, which counts 0 to N-1.
  - DONE: `out_valid` = 1.
- IDLE -> RUN on `in_valid & in_ready`. On that edge:
  - L/R registers load IP(`in_data`).
  - C/D registers load PC1(`in_key`).
  - `in_mode` is captured and `rc` is set to 0.
  - While `in_ready` = 0, `in_valid` is ignored and `in_data`/`in_key`/`in_mode` may change freely.
- RUN, each cycle: apply `ROUNDS_PER_CYCLE` chained rounds combinationally.
  - Each round computes `L' = R` and `R' = L ^ feistel(R, PC2(C,D))`.
  - Absolute round number is `r = rc*ROUNDS_PER_CYCLE + k + 1`, for k from 0 to ROUNDS_PER_CYCLE-1.
- Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt key schedule: before the subkey of round r is formed, C and D each rotate left by S[r].
- Decrypt key schedule:
  - Round 1 uses the unrotated C/D.
  - Before each round r ≥ 2, C and D each rotate right by S[18-r].
  - This yields K16 down to K1 in order.
- Last RUN cycle (`rc` = N-1):
  - `out_data` loads FP(R16 || L16), i.e. the halves are swapped before FP.
  - Transition to DONE.
- DONE -> IDLE on `out_valid & out_ready`. `out_data` holds its value until that handshake.
- No pipelining: at most one block in flight. `in_ready` stays 0 through RUN and DONE.
- `out_ready` is ignored outside DONE.

## Timing
- Reset values while `rst_n` = 0:
  - State is IDLE and `in_ready` = 0.
  - `out_valid` = 0.
  - `out_data` = 0.
  - L/R/C/D = 0 and `rc` = 0.
- `in_ready` = 1 from the first edge after `rst_n` deasserts.
- Latency: input handshake at edge t gives `out_valid` = 1 after edge t+N (16 cycles for R=1, 1 cycle for R=16).
- Throughput: one block per N+2 cycles at best, counting the accept cycle, N RUN cycles and one DONE cycle with `out_ready` = 1. IDLE is re-entered and `in_ready` = 1 in the following cycle.
- `out_ready` held low keeps DONE indefinitely with `out_data` stable.
- Reset asserted mid-RUN or in DONE aborts the block immediately with no output; all registers return to reset values.
- `in_ready` and `out_valid` are decoded from state registers only; there is no combinational path from any input to them.

## Configuration
- `DES_ZEROIZE_EN` defined: on the edge completing the output handshake, L/R, C/D and `out_data` clear to 0. The same clear happens on the IDLE entry that follows reset, so no key-derived state is retained between blocks.
- `DES_ZEROIZE_EN` undefined:
  - L/R, C/D and `out_data` keep their last values after DONE -> IDLE.
  - `out_data` keeps the previous result until the next final RUN cycle.
  - Functional results are identical either way.

## Test plan
- Encrypt, R=1:
  - Stimulus: key 133457799BBCDFF1, data 0123456789ABCDEF, `out_ready` = 1.
  - Required: `out_data` = 85E813540F0AB405, with `out_valid` high exactly 16 cycles after accept.
- Decrypt, same key:
  - Stimulus: data 85E813540F0AB405, `in_mode` = 1.
  - Required: 0123456789ABCDEF.
  - Repeat for R = 2, 4, 8, 16, checking latency = 16/R.
- Encrypt:
  - Stimulus: key 0E329232EA6D0D73, data 8787878787878787.
  - Required: `out_data` = 0000000000000000.
- Backpressure and input masking:
  - Hold `out_ready` = 0 for 20 cycles in DONE. Required: `out_valid` and `out_data` stable.
  - Toggle `in_valid` with new data during RUN/DONE. Required: it is ignored and `in_ready` = 0.
  - Release `out_ready`. Required: `in_ready` = 1 on the next cycle.
- Reset mid-operation:
  - Stimulus: assert `rst_n` = 0 at `rc` = 7 (R=1).
  - Required: `out_valid` = 0 and `out_data` = 0 immediately, with no result emitted.
  - Then a fresh block gives the correct result.
- Zeroization:
  - With `DES_ZEROIZE_EN`: after the output handshake, `out_data` and the internal C/D/L/R read 0.
  - Without it: they retain their last values.
